// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I fetch stage: PC, credit-limited imem requests, instruction buffer, redirect flush.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        busy_flush
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_e;

   state_e        state_q;
   logic          run_q;
   logic [31:0]   pc_q;
   logic [CW-1:0] out_q;
   logic [CW-1:0] drop_q;
   logic [CW-1:0] occ_q;
   logic [AW-1:0] bwr_q;
   logic [AW-1:0] brd_q;
   logic [AW-1:0] pwr_q;
   logic [AW-1:0] prd_q;
   logic [31:0]   bdata_q [DEPTH];
   logic [31:0]   bpc_q   [DEPTH];
   logic [31:0]   pcf_q   [DEPTH];

   logic [CW:0]   inflight;
   logic [CW-1:0] drop_d;
   logic          req_fire;
   logic          rsp_take;
   logic          rsp_drop;
   logic          pop;
   logic          unused_rpc_bits;

   assign unused_rpc_bits = ^redirect_pc[1:0];

   // Credits count buffered words plus words still in flight, so a response always has a slot.
   assign inflight       = {1'b0, occ_q} + {1'b0, out_q};
   assign imem_req_valid = run_q && (state_q == FETCH) && !redirect && (inflight < DEPTH_W);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_take       = imem_rsp_valid && (state_q == FETCH) && (out_q != '0);
   assign rsp_drop       = imem_rsp_valid && (state_q == FLUSH) && (drop_q != '0);
   assign instr_valid    = (occ_q != '0);
   assign pop            = instr_valid && instr_ready;
   assign instr          = bdata_q[brd_q];
   assign instr_pc       = bpc_q[brd_q];
   assign busy_flush     = (state_q == FLUSH);

   always_comb begin
      drop_d = drop_q;
      if (state_q == FLUSH) begin
         drop_d = drop_q - CW'(rsp_drop);
      end else begin
         drop_d = out_q - CW'(rsp_take);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         run_q   <= 1'b0;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
         occ_q   <= '0;
         bwr_q   <= '0;
         brd_q   <= '0;
         pwr_q   <= '0;
         prd_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            bdata_q[i] <= '0;
            bpc_q[i]   <= '0;
            pcf_q[i]   <= '0;
         end
      end else begin
         run_q <= 1'b1;
         if (redirect) begin
            // Everything in flight becomes stale; a response arriving now is already one of them.
            pc_q    <= {redirect_pc[31:2], 2'b00};
            occ_q   <= '0;
            bwr_q   <= '0;
            brd_q   <= '0;
            out_q   <= '0;
            pwr_q   <= '0;
            prd_q   <= '0;
            drop_q  <= drop_d;
            state_q <= (drop_d != '0) ? FLUSH : FETCH;
         end else begin
            if (req_fire) begin
               pc_q         <= pc_q + 32'd4;
               pcf_q[pwr_q] <= pc_q;
               pwr_q        <= pwr_q + 1'b1;
            end
            if (rsp_take) begin
               bdata_q[bwr_q] <= imem_rsp_data;
               bpc_q[bwr_q]   <= pcf_q[prd_q];
               bwr_q          <= bwr_q + 1'b1;
               prd_q          <= prd_q + 1'b1;
            end
            if (pop) begin
               brd_q <= brd_q + 1'b1;
            end
            out_q <= out_q + CW'(req_fire) - CW'(rsp_take);
            occ_q <= occ_q + CW'(rsp_take) - CW'(pop);
            if (state_q == FLUSH) begin
               drop_q <= drop_d;
               if (drop_d == '0) begin
                  state_q <= FETCH;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized bench for instr_fetch against a request/response queue model.
module tb_instr_fetch;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        busy_flush;

   logic        w_req_valid;
   logic [31:0] w_req_addr;
   logic [31:0] w_instr;
   logic [31:0] w_instr_pc;
   logic        w_instr_valid;
   logic        w_busy_flush;

   instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .busy_flush(busy_flush)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
      .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
      .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(1'b0),
      .redirect(1'b0), .redirect_pc(32'h0), .busy_flush(w_busy_flush)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

   req_t        infl[$];
   ins_t        outq[$];
   logic [31:0] exp_pc;
   logic [31:0] w_exp;
   int          w_fires;
   bit          started;
   int          cyc;
   int          lat;
   int          n_vec;
   int          n_err;
   int          n_req;
   bit          d_rr, d_ir, d_redir;
   logic [31:0] d_rpc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0020_8033;
      if (a == 32'h4) return 32'h0020_C1B3;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic int n_stale();
      int n = 0;
      foreach (infl[i]) if (infl[i].stale) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      bit   rsp_f, exp_rv, req_f, pop_f;
      int   ns;
      req_t e;
      ins_t ni;
      rsp_f = (infl.size() != 0) && (infl[0].due <= cyc);
      imem_rsp_valid = rsp_f;
      imem_rsp_data  = rsp_f ? mem_word(infl[0].addr) : $urandom();
      imem_req_ready = d_rr;
      instr_ready    = d_ir;
      redirect       = d_redir;
      redirect_pc    = d_rpc;
      #1;
      ns = n_stale();
      chk("busy_flush", 32'(busy_flush), 32'(ns != 0));
      chk("instr_valid", 32'(instr_valid), 32'(outq.size() != 0));
      if (outq.size() != 0) begin
         chk("instr", instr, outq[0].data);
         chk("instr_pc", instr_pc, outq[0].pc);
      end
      exp_rv = started && (ns == 0) && !d_redir && (outq.size() + infl.size() < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("req_addr", imem_req_addr, exp_pc);
      if (w_req_valid) begin
         chk("wrap_addr", w_req_addr, w_exp);
         w_exp = w_exp + 32'd4;
         w_fires++;
      end
      req_f = exp_rv && d_rr;
      pop_f = (outq.size() != 0) && d_ir;
      if (pop_f) void'(outq.pop_front());
      if (rsp_f) begin
         e = infl.pop_front();
         if (!e.stale && !d_redir) begin
            ni.pc   = e.addr;
            ni.data = mem_word(e.addr);
            outq.push_back(ni);
         end
      end
      if (d_redir) begin
         outq.delete();
         foreach (infl[i]) infl[i].stale = 1'b1;
         exp_pc = {d_rpc[31:2], 2'b00};
      end
      if (req_f) begin
         e.addr  = exp_pc;
         e.due   = cyc + lat;
         e.stale = 1'b0;
         infl.push_back(e);
         exp_pc = exp_pc + 32'd4;
         n_req++;
      end
      started = 1'b1;
      d_redir = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect = 1'b0;
      #1;
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_busy_flush", 32'(busy_flush), 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
      infl.delete();
      outq.delete();
      exp_pc  = 32'h0;
      w_exp   = 32'hFFFF_FFFC;
      w_fires = 0;
      started = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int bp_req;
      n_vec = 0; n_err = 0; n_req = 0; cyc = 0; lat = 1;
      d_rr = 1'b1; d_ir = 1'b1; d_redir = 1'b0; d_rpc = '0;
      @(negedge clk);
      do_reset();

      // Streaming with a 1-cycle memory.
      for (int i = 0; i < 20; i++) step();
      chk("wrap_fires", 32'(w_fires), 32'd2);

      // Decode backpressure.
      d_ir = 1'b0;
      bp_req = n_req;
      for (int i = 0; i < 10; i++) step();
      chk("bp_req_limit", 32'((n_req - bp_req) <= DEPTH), 32'h1);
      d_ir = 1'b1;
      for (int i = 0; i < 10; i++) step();

      // Redirect with two requests outstanding.
      lat = 3;
      for (int i = 0; i < 40 && !(infl.size() == 2 && n_stale() == 0); i++) step();
      chk("setup_two_out", 32'(infl.size() == 2), 32'h1);
      d_redir = 1'b1; d_rpc = 32'h40;
      step();
      chk("flush_entered", 32'(busy_flush), 32'h1);
      for (int i = 0; i < 20; i++) step();

      // Redirect colliding with the only outstanding response, unaligned target.
      lat = 2;
      for (int i = 0; i < 40 && !(infl.size() == 1 && infl[0].due <= cyc && !infl[0].stale); i++) step();
      chk("setup_collide", 32'(infl.size() == 1), 32'h1);
      d_redir = 1'b1; d_rpc = 32'h43;
      step();
      #0;
      chk("collide_no_flush", 32'(busy_flush), 32'h0);
      chk("collide_addr", imem_req_addr, 32'h40);
      for (int i = 0; i < 10; i++) step();

      // Randomized traffic with random redirects.
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) lat = $urandom_range(1, 4);
         d_rr    = ($urandom_range(0, 3) != 0);
         d_ir    = ($urandom_range(0, 2) != 0);
         d_redir = ($urandom_range(0, 15) == 0);
         d_rpc   = $urandom();
         step();
      end

      // Reset in the middle of a two-deep flush.
      d_rr = 1'b1; d_ir = 1'b1; d_redir = 1'b0; lat = 3;
      for (int i = 0; i < 60 && !(infl.size() == 2 && n_stale() == 0); i++) step();
      chk("setup_rst_flush", 32'(infl.size() == 2), 32'h1);
      d_redir = 1'b1; d_rpc = 32'h100;
      step();
      chk("rst_flush_busy", 32'(busy_flush), 32'h1);
      do_reset();
      lat = 1;
      for (int i = 0; i < 20; i++) step();
      chk("wrap_fires_after_rst", 32'(w_fires), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
